// File: rtl/sign_extend16.sv
// Immediate extender for the MIPS datapath: a zero-latency sign extension of a,
// plus a one-stage registered path with selectable extension modes.
module sign_extend16 #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  a,
  output logic [OUT_W-1:0] y,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic [OUT_W-1:0] y_q,
  output logic             out_valid
);

  localparam int EXT_W = OUT_W - IN_W;

  typedef enum logic [1:0] {
    MODE_SIGN   = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_LUI    = 2'b10,
    MODE_BRANCH = 2'b11
  } ext_mode_e;

  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_lui;
  logic [OUT_W-1:0] w_br;
  logic [OUT_W-1:0] w_f;
  ext_mode_e        w_mode;

  logic [OUT_W-1:0] r_y_q;
  logic             r_out_valid;

  assign w_sext = {{EXT_W{a[IN_W-1]}}, a};
  assign w_zext = {{EXT_W{1'b0}}, a};
  assign w_lui  = {a, {EXT_W{1'b0}}};
  // Word offset to byte offset; the top two sign bits fall off the end.
  assign w_br   = {w_sext[OUT_W-3:0], 2'b00};

  assign w_mode = ext_mode_e'(mode);

  always_comb begin
    w_f = w_sext;
    case (w_mode)
      MODE_SIGN:   w_f = w_sext;
      MODE_ZERO:   w_f = w_zext;
      MODE_LUI:    w_f = w_lui;
      MODE_BRANCH: w_f = w_br;
      default:     w_f = w_sext;
    endcase
  end

  // Reset wins over in_valid, so a result in flight is dropped on a reset edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_y_q       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid)
        r_y_q <= w_f;
    end
  end

  assign y         = w_sext;
  assign y_q       = r_y_q;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_sign_extend16.sv
// Directed bench for sign_extend16: combinational sign extension sweep plus
// registered-path modes, hold behaviour and reset priority.
module tb_sign_extend16;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [31:0] y;
  logic [1:0]  mode;
  logic        in_valid;
  logic [31:0] y_q;
  logic        out_valid;

  int n_chk;
  int n_err;

  sign_extend16 #(.IN_W(16), .OUT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .y         (y),
    .mode      (mode),
    .in_valid  (in_valid),
    .y_q       (y_q),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One rising edge, then return at the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [15:0] sw_a [22];
  logic [31:0] sw_y [22];

  initial begin
    sw_a[0]  = 16'h0000; sw_y[0]  = 32'h00000000;
    sw_a[1]  = 16'h0001; sw_y[1]  = 32'h00000001;
    sw_a[2]  = 16'h0002; sw_y[2]  = 32'h00000002;
    sw_a[3]  = 16'h0004; sw_y[3]  = 32'h00000004;
    sw_a[4]  = 16'h0008; sw_y[4]  = 32'h00000008;
    sw_a[5]  = 16'h0010; sw_y[5]  = 32'h00000010;
    sw_a[6]  = 16'h0020; sw_y[6]  = 32'h00000020;
    sw_a[7]  = 16'h0040; sw_y[7]  = 32'h00000040;
    sw_a[8]  = 16'h0080; sw_y[8]  = 32'h00000080;
    sw_a[9]  = 16'h0100; sw_y[9]  = 32'h00000100;
    sw_a[10] = 16'h0200; sw_y[10] = 32'h00000200;
    sw_a[11] = 16'h0400; sw_y[11] = 32'h00000400;
    sw_a[12] = 16'h0800; sw_y[12] = 32'h00000800;
    sw_a[13] = 16'h1000; sw_y[13] = 32'h00001000;
    sw_a[14] = 16'h2000; sw_y[14] = 32'h00002000;
    sw_a[15] = 16'h4000; sw_y[15] = 32'h00004000;
    sw_a[16] = 16'h8000; sw_y[16] = 32'hFFFF8000;
    sw_a[17] = 16'h7FFF; sw_y[17] = 32'h00007FFF;
    sw_a[18] = 16'hFFFF; sw_y[18] = 32'hFFFFFFFF;
    sw_a[19] = 16'h1234; sw_y[19] = 32'h00001234;
    sw_a[20] = 16'hC001; sw_y[20] = 32'hFFFFC001;
    sw_a[21] = 16'h5A5A; sw_y[21] = 32'h00005A5A;
  end

  initial begin
    n_chk    = 0;
    n_err    = 0;
    rst      = 1'b0;
    in_valid = 1'b1;
    a        = 16'h1234;
    mode     = 2'b00;
    #1;
    chk("y_comb_pre_reset", y, 32'h00001234);

    // Two reset edges with in_valid high: register path stays cleared.
    step();
    step();
    chk("rst_y_q", y_q, 32'h00000000);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    a = 16'h8000;
    #1;
    chk("y_comb_in_reset", y, 32'hFFFF8000);

    // All four modes back-to-back on a = FFFE.
    rst = 1'b1; a = 16'hFFFE; in_valid = 1'b1; mode = 2'b00;
    step();
    chk("m00_y_q", y_q, 32'hFFFFFFFE);
    chk("m00_vld", {31'b0, out_valid}, 32'h1);
    mode = 2'b01;
    step();
    chk("m01_y_q", y_q, 32'h0000FFFE);
    chk("m01_vld", {31'b0, out_valid}, 32'h1);
    mode = 2'b10;
    step();
    chk("m10_y_q", y_q, 32'hFFFE0000);
    chk("m10_vld", {31'b0, out_valid}, 32'h1);
    mode = 2'b11;
    step();
    chk("m11_y_q", y_q, 32'hFFFFFFF8);
    chk("m11_vld", {31'b0, out_valid}, 32'h1);

    // Drop in_valid: valid falls, data holds even as a/mode wander.
    in_valid = 1'b0; a = 16'h0F0F; mode = 2'b01;
    step();
    chk("idle_vld", {31'b0, out_valid}, 32'h0);
    chk("idle_hold", y_q, 32'hFFFFFFF8);
    step();
    chk("idle_hold2", y_q, 32'hFFFFFFF8);

    // Boundary values through the registered modes.
    in_valid = 1'b1; a = 16'h8000; mode = 2'b11;
    step();
    chk("br_8000", y_q, 32'hFFFE0000);
    a = 16'h7FFF; mode = 2'b11;
    step();
    chk("br_7FFF", y_q, 32'h0001FFFC);
    mode = 2'b10;
    step();
    chk("lui_7FFF", y_q, 32'h7FFF0000);
    a = 16'h8000; mode = 2'b01;
    step();
    chk("zero_8000", y_q, 32'h00008000);
    mode = 2'b00;
    step();
    chk("sign_8000", y_q, 32'hFFFF8000);

    // Reset arriving alongside a valid input discards that input.
    a = 16'h1234; mode = 2'b00; in_valid = 1'b1; rst = 1'b0;
    step();
    chk("midrst_y_q", y_q, 32'h00000000);
    chk("midrst_vld", {31'b0, out_valid}, 32'h0);
    rst = 1'b1;
    step();
    chk("post_rst_y_q", y_q, 32'h00001234);
    chk("post_rst_vld", {31'b0, out_valid}, 32'h1);

    // Combinational sweep, checked mid-cycle after a settles.
    in_valid = 1'b0;
    for (int i = 0; i < 22; i++) begin
      int e0;
      e0 = n_err;
      a = sw_a[i];
      #2;
      chk($sformatf("sweep_%0d", i), y, sw_y[i]);
      if (n_err == e0) $display("sweep %0d a=%04h y=%08h OK", i, a, y);
      else             $display("sweep %0d a=%04h y=%08h ERROR", i, a, y);
    end
    $display("sweep error total: %0d", n_err);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
